fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined processor; sits directly upstream of the unified memory's instruction port.
- Owns the PC and drives the memory instruction address. Consumes the combinational instruction byte returned for that address.
- Assembles 1- or 2-byte instructions into the IF/ID pipeline register for the decode stage.
- Handles stall from the hazard unit, redirect from branch/jump resolution, and the reset vector at address 0.

Parameters:
- ADDR_W, 8, width of PC and memory address.
- INSTR_W, 8, width of one memory byte / opcode byte.
- IMM_OPC, 4'hC, opcode[7:4] value marking a 2-byte instruction; the second byte is an immediate.
- RESET_VEC_ADDR, 0, address whose contents are loaded into the PC after reset.

Ports:
- clk, in, 1, clock; rising edge.
- rst, in, 1, asynchronous active-low reset.
- stall, in, 1, hazard unit: hold PC, state and IF/ID register.
- redirect, in, 1, taken branch/jump/return from a later stage.
- redirect_pc, in, ADDR_W, target address for redirect.
- i_addr, out, ADDR_W, address to memory instruction port.
- i_data, in, INSTR_W, byte read from memory at i_addr; combinational, same cycle.
- ifid_valid, out, 1, IF/ID register holds a valid instruction.
- ifid_instr, out, INSTR_W, opcode byte.
- ifid_imm, out, INSTR_W, immediate byte; 0 for 1-byte instructions.
- ifid_two_byte, out, 1, instruction carried an immediate.
- ifid_pc_next, out, ADDR_W, address following the last byte of the instruction (return address).
- pc, out, ADDR_W, current PC (debug/interrupt save).

Behaviour:
- Reset (async, rst=0):
  - state=BOOT, pc=0.
  - ifid_valid=0; ifid_instr, ifid_imm, ifid_pc_next all 0; ifid_two_byte=0.
  - Internal opcode hold register = 0.
- i_addr is combinational:
  - RESET_VEC_ADDR in BOOT.
  - pc in every other state.
- States:
  - BOOT: one cycle. pc<=i_data (reset vector). ifid_valid stays 0. Next state OP. stall is ignored in BOOT; redirect in BOOT takes priority (pc<=redirect_pc, state OP).
  - OP, 1-byte instruction (i_data[7:4]!=IMM_OPC): ifid_instr<=i_data, ifid_imm<=0, ifid_two_byte<=0, ifid_pc_next<=pc+1, ifid_valid<=1, pc<=pc+1. Stay in OP.
  - OP, 2-byte instruction (i_data[7:4]==IMM_OPC): opcode hold<=i_data, pc<=pc+1, ifid_valid<=0 (bubble), state IMM.
  - IMM: ifid_instr<=hold, ifid_imm<=i_data, ifid_two_byte<=1, ifid_pc_next<=pc+1, ifid_valid<=1, pc<=pc+1, state OP.
- Priority per cycle, highest first:
  - 1. redirect: pc<=redirect_pc, state<=OP, ifid_valid<=0, hold discarded. Applies even if stall=1.
  - 2. stall: pc, state, hold and all ifid_* keep their values.
  - 3. normal advance, as above.
- Arithmetic: pc+1 is modulo 2^ADDR_W; 8'hFF wraps to 8'h00. No range check against the data region (128..255); software keeps code below it.
- Throughput: 1 instruction/cycle for 1-byte instructions; 2-byte instructions take 2 cycles, with one bubble.
- Latency: the instruction at pc appears on ifid_* one cycle after it is addressed.
- A redirect during IMM drops the partially fetched instruction; it never reaches decode.
- Reset asserted mid-operation returns to BOOT immediately, all outputs at reset values. After release, the vector is re-read.

Test Plan:
- Reset then release with Mem[0]=8'h10, Mem[16]=8'h21 -> BOOT cycle i_addr=0; next cycle pc=16; following edge ifid_valid=1, ifid_instr=8'h21, ifid_pc_next=17.
- Mem[16]=8'hC3, Mem[17]=8'h5A, Mem[18]=8'h40 -> one bubble (ifid_valid=0), then ifid_instr=8'hC3, ifid_imm=8'h5A, ifid_two_byte=1, ifid_pc_next=18; next cycle 8'h40 valid with imm=0.
- stall=1 for 3 cycles while ifid_instr=8'h21 -> pc, i_addr and ifid_* frozen for 3 cycles; resumes at the next address after stall drops.
- In IMM with hold=8'hC3: redirect=1, redirect_pc=8'h30, stall=1 simultaneously -> pc=8'h30, ifid_valid=0, state OP; 8'hC3 is never emitted.
- pc=8'hFF holding a 1-byte instruction -> after the edge, pc=8'h00 and ifid_pc_next=8'h00.
- Assert rst mid-run while in IMM -> outputs immediately at reset values; after release, i_addr=0 for one cycle and the vector is reloaded.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction address and
// assembles 1- or 2-byte instructions into the IF/ID register.
module fetch_stage #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned INSTR_W        = 8,
    parameter logic [3:0]  IMM_OPC        = 4'hC,
    parameter int unsigned RESET_VEC_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  i_addr,
    input  logic [INSTR_W-1:0] i_data,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [INSTR_W-1:0] ifid_imm,
    output logic               ifid_two_byte,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic [ADDR_W-1:0]  pc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        OP   = 2'd1,
        IMM  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic               two_q, two_d;
    logic [ADDR_W-1:0]  pcn_q, pcn_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic               is_imm_op;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign is_imm_op = (i_data[INSTR_W-1 -: 4] == IMM_OPC);

    // Reset vector is fetched from a fixed address during BOOT.
    assign i_addr = (state_q == BOOT) ? ADDR_W'(RESET_VEC_ADDR) : pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            two_q   <= 1'b0;
            pcn_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            two_q   <= two_d;
            pcn_q   <= pcn_d;
        end
    end

    // Priority: redirect, then stall (ignored in BOOT), then normal advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        two_d   = two_q;
        pcn_d   = pcn_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = OP;
            valid_d = 1'b0;
        end else if (stall && (state_q != BOOT)) begin
            state_d = state_q;
        end else begin
            case (state_q)
                BOOT: begin
                    pc_d    = ADDR_W'(i_data);
                    state_d = OP;
                end
                OP: begin
                    pc_d = pc_inc;
                    if (is_imm_op) begin
                        hold_d  = i_data;
                        valid_d = 1'b0;
                        state_d = IMM;
                    end else begin
                        instr_d = i_data;
                        imm_d   = '0;
                        two_d   = 1'b0;
                        pcn_d   = pc_inc;
                        valid_d = 1'b1;
                    end
                end
                IMM: begin
                    instr_d = hold_q;
                    imm_d   = i_data;
                    two_d   = 1'b1;
                    pcn_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    state_d = OP;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    assign ifid_valid    = valid_q;
    assign ifid_instr    = instr_q;
    assign ifid_imm      = imm_q;
    assign ifid_two_byte = two_q;
    assign ifid_pc_next  = pcn_q;
    assign pc            = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model plus a queue of expected
// IF/ID records, checked with immediate assertions.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] i_addr;
    logic [7:0] i_data;
    logic       ifid_valid;
    logic [7:0] ifid_instr;
    logic [7:0] ifid_imm;
    logic       ifid_two_byte;
    logic [7:0] ifid_pc_next;
    logic [7:0] pc;

    logic [7:0] mem [256];

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] imm;
        logic       two;
        logic [7:0] pcn;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    assign i_data = mem[i_addr];

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_imm     (ifid_imm),
        .ifid_two_byte(ifid_two_byte),
        .ifid_pc_next (ifid_pc_next),
        .pc           (pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] instr, input logic [7:0] imm,
                        input logic two, input logic [7:0] pcn);
        exp_t e;
        e.instr = instr;
        e.imm   = imm;
        e.two   = two;
        e.pcn   = pcn;
        exp_q.push_back(e);
    endtask

    task automatic check_ifid(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(ifid_valid),    32'd1);
            chk({tag, "_instr"}, 32'(ifid_instr),    32'(e.instr));
            chk({tag, "_imm"},   32'(ifid_imm),      32'(e.imm));
            chk({tag, "_two"},   32'(ifid_two_byte), 32'(e.two));
            chk({tag, "_pcn"},   32'(ifid_pc_next),  32'(e.pcn));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pc"},    32'(pc),            32'd0);
        chk({tag, "_iaddr"}, 32'(i_addr),        32'd0);
        chk({tag, "_valid"}, 32'(ifid_valid),    32'd0);
        chk({tag, "_instr"}, 32'(ifid_instr),    32'd0);
        chk({tag, "_imm"},   32'(ifid_imm),      32'd0);
        chk({tag, "_two"},   32'(ifid_two_byte), 32'd0);
        chk({tag, "_pcn"},   32'(ifid_pc_next),  32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        mem[8'h00] = 8'h10;
        mem[8'h10] = 8'h21;
        mem[8'h11] = 8'h22;
        mem[8'h20] = 8'hC3;
        mem[8'h21] = 8'h5A;
        mem[8'h22] = 8'h40;
        mem[8'h23] = 8'hC3;
        mem[8'h24] = 8'h77;
        mem[8'h30] = 8'h11;
        mem[8'hFF] = 8'h12;

        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;

        // Reset state and boot vector load
        step();
        step();
        check_reset_vals("rst");
        rst = 1'b1;
        chk("boot_iaddr", 32'(i_addr), 32'h00);
        step();
        chk("boot_pc",    32'(pc),         32'h10);
        chk("boot_iaddr2", 32'(i_addr),    32'h10);
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        push(8'h21, 8'h00, 1'b0, 8'h11);
        step();
        check_ifid("first");
        chk("first_pc", 32'(pc), 32'h11);

        // Stall three cycles with 0x21 in IF/ID
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",    32'(pc),         32'h11);
            chk("stall_iaddr", 32'(i_addr),     32'h11);
            chk("stall_instr", 32'(ifid_instr), 32'h21);
            chk("stall_valid", 32'(ifid_valid), 32'd1);
            chk("stall_pcn",   32'(ifid_pc_next), 32'h11);
        end
        stall = 1'b0;
        push(8'h22, 8'h00, 1'b0, 8'h12);
        step();
        check_ifid("resume");

        // Two-byte instruction with bubble, then a one-byte follower
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        step();
        redirect = 1'b0;
        chk("redir_pc",    32'(pc),         32'h20);
        chk("redir_valid", 32'(ifid_valid), 32'd0);
        step();
        chk("bubble_valid", 32'(ifid_valid), 32'd0);
        chk("bubble_pc",    32'(pc),         32'h21);
        push(8'hC3, 8'h5A, 1'b1, 8'h22);
        step();
        check_ifid("imm_instr");
        push(8'h40, 8'h00, 1'b0, 8'h23);
        step();
        check_ifid("after_imm");

        // Redirect with stall while in IMM drops the held opcode
        step();
        chk("imm2_bubble", 32'(ifid_valid), 32'd0);
        chk("imm2_pc",     32'(pc),         32'h24);
        redirect    = 1'b1;
        redirect_pc = 8'h30;
        stall       = 1'b1;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("drop_pc",    32'(pc),         32'h30);
        chk("drop_iaddr", 32'(i_addr),     32'h30);
        chk("drop_valid", 32'(ifid_valid), 32'd0);
        push(8'h11, 8'h00, 1'b0, 8'h31);
        step();
        check_ifid("drop_next");

        // PC wrap at 0xFF
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        chk("wrap_pre_pc", 32'(pc), 32'hFF);
        push(8'h12, 8'h00, 1'b0, 8'h00);
        step();
        check_ifid("wrap");
        chk("wrap_pc", 32'(pc), 32'h00);

        // Asynchronous reset while in IMM, then vector reload
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        step();
        redirect = 1'b0;
        step();
        chk("pre_rst_valid", 32'(ifid_valid), 32'd0);
        chk("pre_rst_pc",    32'(pc),         32'h21);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b1;
        chk("reboot_iaddr", 32'(i_addr), 32'h00);
        push(8'h21, 8'h00, 1'b0, 8'h11);
        step();
        chk("reboot_pc",    32'(pc),         32'h10);
        chk("reboot_valid", 32'(ifid_valid), 32'd0);
        step();
        check_ifid("reboot");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
